code842m1_to_bcd_deserializer: RTL

//  Receiver-side counterpart of the BCD->84-2-1' converter. Accepts a stream of 4-bit 84-2-1' digits

---
 rtl/code842m1_to_bcd_deserializer_pkg.sv | 38 +++
 rtl/code842m1_to_bcd_deserializer_digit_decode.sv | 16 +
 rtl/code842m1_to_bcd_deserializer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/code842m1_to_bcd_deserializer_pkg.sv
// Shared types and the 84-2-1' digit decode function for the 84-2-1' -> BCD deserializer.
package code_conv_pkg;

    typedef logic [3:0] code842_t;
    typedef logic [3:0] bcd_t;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } conv_state_e;

    localparam bcd_t BCD_INVALID = 4'hF;

    typedef struct packed {
        bcd_t bcd;
        logic err;
    } dec_t;

    // Weights 8,4,-2,-1; the six codes whose weighted sum falls outside 0..9 are flagged.
    function automatic dec_t decode_842m1(input code842_t code);
        dec_t r;
        case (code)
            4'b0000: r = '{bcd: 4'd0, err: 1'b0};
            4'b0100: r = '{bcd: 4'd4, err: 1'b0};
            4'b0101: r = '{bcd: 4'd3, err: 1'b0};
            4'b0110: r = '{bcd: 4'd2, err: 1'b0};
            4'b0111: r = '{bcd: 4'd1, err: 1'b0};
            4'b1000: r = '{bcd: 4'd8, err: 1'b0};
            4'b1001: r = '{bcd: 4'd7, err: 1'b0};
            4'b1010: r = '{bcd: 4'd6, err: 1'b0};
            4'b1011: r = '{bcd: 4'd5, err: 1'b0};
            4'b1111: r = '{bcd: 4'd9, err: 1'b0};
            default: r = '{bcd: BCD_INVALID, err: 1'b1};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/code842m1_to_bcd_deserializer_digit_decode.sv
// Combinational single-digit 84-2-1' to BCD decoder with invalid-code flag.
module code842m1_digit_decode
    import code_conv_pkg::*;
(
    input  code842_t i_code,
    output bcd_t     o_bcd,
    output logic     o_err
);

    dec_t w_dec;

    assign w_dec = decode_842m1(i_code);
    assign o_bcd = w_dec.bcd;
    assign o_err = w_dec.err;

endmodule

// File: rtl/code842m1_to_bcd_deserializer.sv
// Packs DIGITS decoded 84-2-1' digits into one BCD word (first digit in MSBs) behind
// valid/ready handshakes on both sides, with per-word error flag and saturating error count.
module code842m1_to_bcd_deserializer
    import code_conv_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int ERR_CW = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enb,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_code,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_err,
    output logic [ERR_CW-1:0]     err_count
);

    localparam int                IDXW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDXW-1:0]   LAST_IDX = IDXW'(DIGITS - 1);
    localparam logic [ERR_CW-1:0] ERR_MAX  = {ERR_CW{1'b1}};

    conv_state_e            r_state;
    conv_state_e            w_state_next;
    logic [IDXW-1:0]        r_idx;
    logic [4*DIGITS-1:0]    r_acc;
    logic                   r_acc_err;
    logic [4*DIGITS-1:0]    r_out_bcd;
    logic                   r_out_err;
    logic                   r_out_valid;
    logic [ERR_CW-1:0]      r_err_count;

    bcd_t                   w_bcd;
    logic                   w_err;
    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_last;
    logic [4*DIGITS-1:0]    w_acc_next;

    code842m1_digit_decode u_decode (
        .i_code (in_code),
        .o_bcd  (w_bcd),
        .o_err  (w_err)
    );

    // rst_n gates in_ready so nothing is offered as accepted while the block is held in reset.
    assign w_in_ready = rst_n & enb & (r_state == COLLECT);
    assign w_accept   = in_valid & w_in_ready;
    assign w_last     = (r_idx == LAST_IDX);

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_bcd    = r_out_bcd;
    assign out_err    = r_out_err;
    assign err_count  = r_err_count;

    // Accumulator with the incoming digit written into the lane selected by the index.
    always_comb begin
        w_acc_next = r_acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_acc_next[4*(DIGITS-1-i) +: 4] = w_bcd;
            end else begin
                w_acc_next[4*(DIGITS-1-i) +: 4] = r_acc[4*(DIGITS-1-i) +: 4];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: complete word moves to HOLD, output handshake returns to COLLECT.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            COLLECT: begin
                if (w_accept && w_last) begin
                    w_state_next = HOLD;
                end else begin
                    w_state_next = COLLECT;
                end
            end
            HOLD: begin
                if (r_out_valid && out_ready) begin
                    w_state_next = COLLECT;
                end else begin
                    w_state_next = HOLD;
                end
            end
            default: w_state_next = COLLECT;
        endcase
    end

    // Word assembly and output holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_acc       <= '0;
            r_acc_err   <= 1'b0;
            r_out_bcd   <= '0;
            r_out_err   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (!enb) begin
                        r_idx     <= '0;
                        r_acc     <= '0;
                        r_acc_err <= 1'b0;
                    end else if (w_accept && w_last) begin
                        r_out_bcd   <= w_acc_next;
                        r_out_err   <= r_acc_err | w_err;
                        r_out_valid <= 1'b1;
                        r_idx       <= '0;
                        r_acc       <= '0;
                        r_acc_err   <= 1'b0;
                    end else if (w_accept) begin
                        r_acc     <= w_acc_next;
                        r_acc_err <= r_acc_err | w_err;
                        r_idx     <= r_idx + IDXW'(1);
                    end
                end
                HOLD: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of accepted invalid digits; independent of enb and word discards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (w_accept && w_err && (r_err_count != ERR_MAX)) begin
            r_err_count <= r_err_count + ERR_CW'(1);
        end
    end

endmodule
